// File: rtl/semi_cmd_filter.sv
// semi_cmd_filter: synchronises/debounces buttons and line detectors, holds a one-hot command until acked
module semi_cmd_filter #(
    parameter int         DB_CYCLES  = 1000000,
    parameter int         DET_CYCLES = 100000,
    parameter logic [3:0] DET_RST    = 4'b0110
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_straight,
    input  logic       btn_back,
    input  logic [3:0] detector_raw,
    input  logic       cmd_ack,
    output logic       turn_left,
    output logic       turn_right,
    output logic       go_straight,
    output logic       go_back,
    output logic       cmd_valid,
    output logic [3:0] detector,
    output logic       crossroad
);
    typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
    localparam logic [7:0] RST_VEC = {DET_RST, 4'b0000};
    state_t     state, state_d;
    logic [7:0] raw, stable;
    logic [3:0] btn_prev, press, cmd, cmd_d;
    // bit order: [3:0] buttons {back,left,right,straight} (descending priority), [7:4] detectors
    assign raw = {detector_raw, btn_back, btn_left, btn_right, btn_straight};
    for (genvar i = 0; i < 8; i++) begin : g_in
        localparam int            WINDOW = i < 4 ? DB_CYCLES : DET_CYCLES;
        localparam int            CW     = $clog2(WINDOW);
        localparam logic [CW-1:0] LAST   = CW'(WINDOW - 1);
        logic [1:0]    sync;
        logic [CW-1:0] cnt;
        logic          st;
        always_ff @(posedge sys_clk or posedge rst) begin
            if (rst) begin
                sync <= {2{RST_VEC[i]}};
                st   <= RST_VEC[i];
                cnt  <= '0;
            end else begin
                sync <= {sync[0], raw[i]};
                if (sync[1] == st) cnt <= '0;
                else if (cnt == LAST) begin
                    st  <= sync[1];
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
            end
        end
        assign stable[i] = st;
    end
    assign press = stable[3:0] & ~btn_prev;
    always_comb begin
        state_d = state;
        cmd_d   = cmd;
        if (!power) begin
            state_d = IDLE;
            cmd_d   = '0;
        end else begin
            case (state)
                IDLE: if (press != 4'b0000) begin
                    state_d = HOLD;
                    cmd_d   = press[3] ? 4'b1000 : press[2] ? 4'b0100 : press[1] ? 4'b0010 : 4'b0001;
                end
                HOLD: if (cmd_ack) begin
                    state_d = RELEASE;
                    cmd_d   = '0;
                end
                RELEASE: state_d = stable[3:0] == 4'b0000 ? IDLE : RELEASE;
                default: begin
                    state_d = IDLE;
                    cmd_d   = '0;
                end
            endcase
        end
    end
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd       <= '0;
            btn_prev  <= '0;
            crossroad <= 1'b0;
        end else begin
            state     <= state_d;
            cmd       <= cmd_d;
            btn_prev  <= stable[3:0];
            crossroad <= stable[4] | ~stable[5] | ~stable[6];
        end
    end
    assign detector    = stable[7:4];
    assign go_back     = cmd[3];
    assign turn_left   = cmd[2];
    assign turn_right  = cmd[1];
    assign go_straight = cmd[0];
    assign cmd_valid   = |cmd;
endmodule

// File: tb/tb_semi_cmd_filter.sv
// tb_semi_cmd_filter: directed + randomized stimulus against a sliding-window reference model
module tb_semi_cmd_filter;
    localparam int         DB = 4;
    localparam int         DT = 3;
    localparam logic [3:0] DR = 4'b0110;
    logic       clk = 1'b0, rst = 1'b0, power = 1'b1, ack = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] det_raw = DR;
    logic       turn_left, turn_right, go_straight, go_back, cmd_valid, crossroad;
    logic [3:0] detector;
    int         checks = 0, errors = 0;
    logic [7:0] raw_q[$];
    logic [7:0] syn_q[$];
    logic [7:0] m_stable;
    logic [3:0] m_prev, m_cmd;
    logic       m_cross;
    int         m_mode;

    always #5 clk = ~clk;

    semi_cmd_filter #(.DB_CYCLES(DB), .DET_CYCLES(DT), .DET_RST(DR)) dut (
        .sys_clk(clk), .rst(rst), .power(power),
        .btn_left(btn[2]), .btn_right(btn[1]), .btn_straight(btn[0]), .btn_back(btn[3]),
        .detector_raw(det_raw), .cmd_ack(ack),
        .turn_left(turn_left), .turn_right(turn_right), .go_straight(go_straight), .go_back(go_back),
        .cmd_valid(cmd_valid), .detector(detector), .crossroad(crossroad)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] cmd_out();
        return {go_back, turn_left, turn_right, go_straight};
    endfunction

    task automatic model_reset();
        raw_q.delete();
        syn_q.delete();
        m_stable = {DR, 4'b0000};
        m_prev   = 4'b0000;
        m_cmd    = 4'b0000;
        m_cross  = 1'b0;
        m_mode   = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_cmd", {4'b0, cmd_out()}, 8'h0);
        chk("rst_valid", {7'b0, cmd_valid}, 8'h0);
        chk("rst_det", {4'b0, detector}, {4'b0, DR});
        chk("rst_cross", {7'b0, crossroad}, 8'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // stable flips once the last W synced samples all disagree with it; synced = raw from two edges back
    task automatic tick();
        logic [7:0] s, ns;
        logic [3:0] press;
        int         w;
        bit         all;
        @(posedge clk);
        raw_q.push_back({det_raw, btn});
        s = raw_q.size() >= 3 ? raw_q[raw_q.size() - 3] : {DR, 4'b0000};
        syn_q.push_back(s);
        ns = m_stable;
        for (int b = 0; b < 8; b++) begin
            w = b < 4 ? DB : DT;
            all = syn_q.size() >= w;
            for (int j = 0; j < w; j++)
                if (all && syn_q[syn_q.size() - 1 - j][b] == m_stable[b]) all = 1'b0;
            if (all) ns[b] = ~m_stable[b];
        end
        press = m_stable[3:0] & ~m_prev;
        if (!power) begin
            m_cmd  = 4'b0000;
            m_mode = 0;
        end else if (m_mode == 0) begin
            for (int b = 0; b < 4; b++) if (press[b]) m_cmd = 4'b0001 << b;
            if (m_cmd != 4'b0000) m_mode = 1;
        end else if (m_mode == 1) begin
            if (ack) begin
                m_cmd  = 4'b0000;
                m_mode = 2;
            end
        end else if (m_stable[3:0] == 4'b0000) m_mode = 0;
        m_prev   = m_stable[3:0];
        m_cross  = m_stable[4] | ~m_stable[5] | ~m_stable[6];
        m_stable = ns;
        #1;
        chk("cmd", {4'b0, cmd_out()}, {4'b0, m_cmd});
        chk("valid", {7'b0, cmd_valid}, {7'b0, |m_cmd});
        chk("det", {4'b0, detector}, {4'b0, m_stable[7:4]});
        chk("cross", {7'b0, crossroad}, {7'b0, m_cross});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #1;
        do_reset();
        // clean left press: command appears after edge 6, not before
        btn = 4'b0100;
        ticks(6);
        chk("d_left_e5", {4'b0, cmd_out()}, 8'h00);
        tick();
        chk("d_left_e6", {4'b0, cmd_out()}, 8'h04);
        chk("d_left_valid", {7'b0, cmd_valid}, 8'h01);
        // back pressed during HOLD is ignored; ack clears; held left does not re-issue
        btn = 4'b1100;
        ticks(8);
        chk("d_hold_keep", {4'b0, cmd_out()}, 8'h04);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("d_ack_clear", {4'b0, cmd_out()}, 8'h00);
        ticks(10);
        chk("d_no_reissue", {4'b0, cmd_out()}, 8'h00);
        btn = 4'b0000;
        ticks(10);
        btn = 4'b0100;
        ticks(7);
        chk("d_repress", {4'b0, cmd_out()}, 8'h04);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        btn = 4'b0000;
        ticks(10);
        // short right pulse is filtered out
        btn = 4'b0010;
        ticks(3);
        btn = 4'b0000;
        ticks(10);
        chk("d_pulse", {4'b0, cmd_out()}, 8'h00);
        // simultaneous back + straight: back wins
        btn = 4'b1001;
        ticks(7);
        chk("d_prio", {4'b0, cmd_out()}, 8'h08);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        btn = 4'b0000;
        ticks(10);
        // detector path
        det_raw = 4'b0100;
        ticks(4);
        chk("d_det_e3", {4'b0, detector}, {4'b0, DR});
        tick();
        chk("d_det_e4", {4'b0, detector}, 8'h04);
        chk("d_cross_e4", {7'b0, crossroad}, 8'h00);
        tick();
        chk("d_cross_e5", {7'b0, crossroad}, 8'h01);
        det_raw = 4'b0010;
        ticks(2);
        det_raw = 4'b0100;
        ticks(10);
        chk("d_glitch", {4'b0, detector}, 8'h04);
        // reset in HOLD, then re-press via debounce, then power drop
        btn = 4'b0100;
        ticks(7);
        chk("d_hold2", {4'b0, cmd_out()}, 8'h04);
        do_reset();
        ticks(7);
        chk("d_post_rst", {4'b0, cmd_out()}, 8'h04);
        power = 1'b0;
        tick();
        chk("d_power_off", {4'b0, cmd_out()}, 8'h00);
        power = 1'b1;
        ticks(10);
        chk("d_power_held", {4'b0, cmd_out()}, 8'h00);
        btn = 4'b0000;
        ticks(10);
        // randomized phase
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) btn = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 9) == 0) det_raw = 4'($urandom);
            ack = $urandom_range(0, 5) == 0;
            power = $urandom_range(0, 49) != 0;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
